mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//   Two-input round-robin stream arbiter; sits directly upstream of the 2x1 mux stage.
//   Picks one of two valid/ready sources, drives SEL for the mux datapath.
//   Registers the winning word into a one-entry output stage, so the consumer sees
//   OUT_DATA plus the source tag SEL.
//   Fair: on contention, the grant alternates between A and B.
// PARAMETERS
//   WIDTH      8   data width of A_DATA, B_DATA, OUT_DATA
//   FIRST_SEL  0   input favoured on the first contention after reset (0=A, 1=B)
// PORTS
//   CLK        in   1      rising-edge clock; the only clock
//   RST_N      in   1      asynchronous reset, active-low; deassert synchronously to CLK
//   A_DATA     in   WIDTH  source A payload
//   A_VALID    in   1      source A has a word
//   A_READY    out  1      A word accepted this cycle when A_VALID & A_READY
//   B_DATA     in   WIDTH  source B payload
//   B_VALID    in   1      source B has a word
//   B_READY    out  1      B word accepted this cycle when B_VALID & B_READY
//   OUT_DATA   out  WIDTH  registered winning word
//   OUT_VALID  out  1      OUT_DATA/SEL hold a word
//   OUT_READY  in   1      consumer takes the word when OUT_VALID & OUT_READY
//   SEL        out  1      source of the current OUT_DATA (0=A, 1=B); mux select
// BEHAVIOUR
//   Reset (async, RST_N=0):
//     OUT_VALID=0, OUT_DATA=0, SEL=0, LAST=~FIRST_SEL.
//     A_READY and B_READY read 0 while RST_N=0.
//     A reset mid-transfer drops the held word; no transfer completes in that cycle.
//   States: EMPTY (OUT_VALID=0), FULL (OUT_VALID=1).
//   load_en = ~OUT_VALID | OUT_READY.
//     Pass-through ready: a word can enter in the same cycle the held word leaves.
//   Grant (combinational):
//     - only A_VALID -> A
//     - only B_VALID -> B
//     - both valid   -> ~LAST
//     - neither      -> no grant
//   A_READY = load_en & grant==A.
//   B_READY = load_en & grant==B.
//     At most one READY is high per cycle; the loser's READY stays 0.
//   On an accepted input: OUT_DATA<=winner data, SEL<=winner, LAST<=winner, OUT_VALID<=1.
//   OUT_VALID & OUT_READY with no accepted input: OUT_VALID<=0.
//     OUT_DATA and SEL hold their last value.
//   Transitions:
//     EMPTY->FULL on accept.
//     FULL->FULL on accept with OUT_READY, or on stall (OUT_READY=0).
//     FULL->EMPTY on OUT_READY with no valid input.
//   Stall (FULL & ~OUT_READY): OUT_DATA, SEL, OUT_VALID are held stable; both READYs are 0.
//   LAST updates only on an accepted transfer.
//     Stalls and idle cycles do not change LAST.
//   Latency: input accept -> OUT_VALID in 1 cycle.
//   Throughput: 1 word/cycle with OUT_READY held high.
//   Sources must hold DATA/VALID until their READY is seen; the arbiter never drops an accepted word.
//   No combinational path from A_VALID/B_VALID to OUT_*; the READYs depend on OUT_READY.
// TESTING
//   1 Reset: RST_N=0 with A_VALID=B_VALID=1 -> OUT_VALID=0, SEL=0, OUT_DATA=0, A_READY=B_READY=0.
//   2 Single source: A_DATA=0x3C, A_VALID=1 one cycle, OUT_READY=1
//       -> next cycle OUT_VALID=1, OUT_DATA=0x3C, SEL=0.
//   3 Contention: A=0x11, B=0x22 held valid 4 cycles, OUT_READY=1, FIRST_SEL=0
//       -> OUT_DATA sequence 0x11,0x22,0x11,0x22; SEL sequence 0,1,0,1.
//   4 Backpressure: FULL with 0xAA, OUT_READY=0 for 3 cycles
//       -> OUT_DATA=0xAA stable, A_READY=B_READY=0.
//       -> OUT_READY=1 then releases 0xAA and loads the next granted word the same cycle.
//   5 Async reset mid-stream: drop RST_N between clock edges while FULL
//       -> OUT_VALID=0 immediately with no clock edge; first tie after release goes to FIRST_SEL.
//   6 Drain: FULL, OUT_READY=1, no valid inputs
//       -> OUT_VALID=0 next cycle; SEL and OUT_DATA unchanged.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin stream arbiter with a one-entry registered output stage.
// Picks A or B, registers the winning word and its source tag (sel), and
// alternates the grant between the two sources whenever both are valid.
module mux2_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          FIRST_SEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,

    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,

    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             sel_q;
    // Source of the most recent accepted word; a tie goes to the other one.
    logic             last_q;

    logic             load_en;
    logic             grant_b;
    logic             accept;

    // Grant and handshake decode; ready depends on out_ready, never on out_* state alone.
    always_comb begin
        load_en = (state_q == StEmpty) | out_ready;
        // B wins when it is the only requester, or on a tie when A went last.
        grant_b = b_valid & (~a_valid | ~last_q);
        // Gate with rst_n so both readys read 0 while reset is held.
        a_ready = rst_n & load_en & a_valid & ~grant_b;
        b_ready = rst_n & load_en & grant_b;
        accept  = a_ready | b_ready;
    end

    // Output stage state machine: load on accept, drain on out_ready, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= 1'b0;
            last_q  <= ~FIRST_SEL;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        data_q  <= grant_b ? b_data : a_data;
                        sel_q   <= grant_b;
                        last_q  <= grant_b;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (accept) begin
                        // Held word leaves and the new one enters in the same cycle.
                        data_q  <= grant_b ? b_data : a_data;
                        sel_q   <= grant_b;
                        last_q  <= grant_b;
                        state_q <= StFull;
                    end else if (out_ready) begin
                        // Drain: data and tag keep their last value.
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = (state_q == StFull);
        out_data  = data_q;
        sel       = sel_q;
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter with a scoreboard of expected {sel, data}.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data, b_data, out_data;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic       out_valid, out_ready, sel;

    int total = 0;
    int bad   = 0;

    // Expected words in flight: {sel, data}
    logic [8:0] sb[$];
    logic       m_last;
    logic [7:0] hold_data;
    logic       hold_sel;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .WIDTH    (8),
        .FIRST_SEL(1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel      (sel)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_last    = 1'b1;  // ~FIRST_SEL
        hold_data = 8'h00;
        hold_sel  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check mid-low phase, update model at posedge.
    task automatic step(input logic av, input logic [7:0] ad, input logic bv,
                        input logic [7:0] bd, input logic ordy);
        logic full, load, gb, ea, eb;
        logic [8:0] e_out;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
        #1;
        full  = (sb.size() != 0);
        load  = !full || ordy;
        gb    = bv && (!av || !m_last);
        ea    = load && av && !gb;
        eb    = load && gb;
        e_out = full ? sb[0] : {hold_sel, hold_data};
        chk("out_valid", {8'b0, out_valid}, {8'b0, full});
        chk("out_data", {1'b0, out_data}, {1'b0, e_out[7:0]});
        chk("sel", {8'b0, sel}, {8'b0, e_out[8]});
        chk("a_ready", {8'b0, a_ready}, {8'b0, ea});
        chk("b_ready", {8'b0, b_ready}, {8'b0, eb});
        @(posedge clk);
        if (full && ordy) void'(sb.pop_front());
        if (ea || eb) begin
            sb.push_back({gb, gb ? bd : ad});
            m_last    = gb;
            hold_sel  = gb;
            hold_data = gb ? bd : ad;
        end
        @(negedge clk);
    endtask

    initial begin
        // 1: reset with both sources valid
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = 8'h55; b_data = 8'h66; out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {8'b0, out_valid}, 9'h0);
        chk("rst_out_data", {1'b0, out_data}, 9'h0);
        chk("rst_sel", {8'b0, sel}, 9'h0);
        chk("rst_a_ready", {8'b0, a_ready}, 9'h0);
        chk("rst_b_ready", {8'b0, b_ready}, 9'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 3: contention, four cycles, first tie to A
        repeat (4) step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("contention_last_sel", {8'b0, sel}, 9'h1);

        // 6: drain, data and sel unchanged
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // 2: single source A
        step(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("single_data", {1'b0, out_data}, 9'h03C);

        // 4: backpressure with 0xAA held, then release with pass-through load
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1);
        repeat (3) step(1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
        step(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("bp_next_data", {1'b0, out_data}, 9'h077);

        // B alone, then tie goes back to A
        step(1'b0, 8'h00, 1'b1, 8'h99, 1'b1);
        step(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // 5: async reset while full, between clock edges
        step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_out_valid", {8'b0, out_valid}, 9'h0);
        chk("async_out_data", {1'b0, out_data}, 9'h0);
        chk("async_a_ready", {8'b0, a_ready}, 9'h0);
        chk("async_b_ready", {8'b0, b_ready}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("tie_after_reset_sel", {8'b0, sel}, 9'h0);
        chk("tie_after_reset_data", {1'b0, out_data}, 9'h0C1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
